mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single shared unified main memory between the instruction-cache miss path and the data-cache miss/write-through path of the pipelined 16-bit CPU. Each transaction is one of two kinds. A cache miss becomes an 8-word block fill. A write-through becomes a single-word write. The block sits between the two cache controllers and the memory model. It owns every memory control signal and streams returned words back to the requesting cache.

## Interface
- `ADDR_W`, 16: byte address width.
- `DATA_W`, 16: word width.
- `BLOCK_WORDS`, 8: words per cache block (power of 2).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_miss`  in  1  I-cache requests a block fill; held until `i_fill_done`.
- `i_miss_addr`  in  ADDR_W  I-cache miss byte address.
- `d_miss`  in  1  D-cache requests a block fill; held until `d_fill_done`.
- `d_miss_addr`  in  ADDR_W  D-cache miss byte address.
- `d_wr`  in  1  D-cache write-through request; held until `d_wr_done`.
- `d_wr_addr`  in  ADDR_W  write byte address.
- `d_wr_data`  in  DATA_W  write data.
- `mem_en`  out  1  memory access this cycle.
- `mem_wr`  out  1  access is a write (valid with `mem_en`).
- `mem_addr`  out  ADDR_W  memory byte address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.
- `mem_rvalid`  in  1  `mem_rdata` valid; one pulse per issued read, in order.
- `fill_valid`  out  1  `fill_data` is a returned block word.
- `fill_data`  out  DATA_W  returned word (= `mem_rdata`).
- `fill_word`  out  log2(BLOCK_WORDS)  index of returned word within block.
- `fill_to_d`  out  1  fill target: 1 = D-cache, 0 = I-cache.
- `i_fill_done`, `d_fill_done`, `d_wr_done`  out  1 each  one-cycle completion pulses.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Reset: all outputs 0, state IDLE, counters 0, `settle` flag clear.
- States: IDLE, WRITE, FILL, DONE.
- IDLE: requests are sampled only when `settle` is clear.
  - Priority: `d_wr` > `d_miss` > `i_miss`.
  - Chosen request's address and data are latched.
  - `d_wr` → WRITE; a miss → FILL with issue count and return count cleared.
- WRITE, lasting one cycle:
  - `mem_en`=1, `mem_wr`=1, `mem_addr`=latched addr, `mem_wdata`=latched data.
  - Then → DONE.
- FILL:
  - Base address = latched addr with low log2(BLOCK_WORDS)+1 bits cleared.
  - Issue phase: while issue count < BLOCK_WORDS, drive `mem_en`=1, `mem_wr`=0, `mem_addr`=base+2·issue; issue count increments every cycle.
  - Return phase: each `mem_rvalid` drives `fill_valid`=1, `fill_data`=`mem_rdata`, `fill_word`=return count, then return count increments.
  - The issue and return phases overlap.
  - → DONE on the cycle the BLOCK_WORDS-th return is accepted.
- DONE, lasting one cycle: pulse the done output matching the latched kind, set `settle`, → IDLE.
- `settle`: cleared after the first IDLE cycle. This gives the requester one cycle to drop its request and prevents double-servicing.
- `fill_to_d` is held at the latched target from FILL entry until the next FILL.
- `mem_rvalid` outside FILL is ignored; `fill_valid` stays 0.
- Address arithmetic is modulo 2^ADDR_W. The block base is aligned, so no wrap occurs within a block.

## Timing
- Request high in IDLE at cycle T, `settle` clear, state registered at the edge ending T.
- Write: memory write in cycle T+1; `d_wr_done` in T+2; next grant no earlier than T+4.
- Fill issue: reads are issued in T+1 .. T+BLOCK_WORDS.
- Fill completion: with memory latency L (the 4-cycle model), word k returns at T+1+k+L. The last word returns at T+12; done pulses at T+13.
- Fill latency is set by the memory; the arbiter never assumes a fixed L.
- Simultaneous requests: the lower-priority request waits and is re-evaluated in the next eligible IDLE cycle.
- Reset mid-transaction: returns to IDLE next cycle, no done pulse. The memory shares `rst`, so no stale returns.

## Configuration
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority `d_wr` > `d_miss` > `i_miss`.
- `ARB_ROUND_ROBIN_EN` defined:
  - `d_wr` keeps top priority.
  - Between `d_miss` and `i_miss`, the requester not served by the most recent fill wins when both are high.
  - The last-fill pointer resets to I-cache, so D-cache wins the first tie.

## Test plan
- `d_wr` addr 0x0040 data 0xBEEF → one cycle with `mem_en`=1, `mem_wr`=1, addr 0x0040, wdata 0xBEEF; `d_wr_done` two cycles after request.
- `i_miss` addr 0x1236, 4-cycle memory → reads 0x1230..0x123E on consecutive cycles; `fill_word` 0..7, `fill_to_d`=0; `i_fill_done` at T+13.
- `i_miss` and `d_miss` asserted the same cycle (macro off) → D fill first, then I fill. With macro on, two back-to-back ties alternate D, I.
- `d_wr` raised during an I fill → no memory write until after `i_fill_done` plus the settle cycle; write then precedes any pending miss.
- `rst` asserted at the 3rd return of a fill → next cycle IDLE, all outputs 0, no done pulse; a new `d_miss` completes normally.
- `mem_rvalid` pulsed while IDLE → `fill_valid` stays 0 and the counters are unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: I-cache fills, D-cache fills, D-cache write-through.
// Define ARB_ROUND_ROBIN_EN to alternate D/I fill ties instead of fixed D-first.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [DATA_W-1:0]              d_wr_data,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_rvalid,
  output logic                           fill_valid,
  output logic [DATA_W-1:0]              fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           fill_to_d,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           d_wr_done,
  output logic                           busy
);

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int CW = WW + 1;
  localparam logic [ADDR_W-1:0] LowMask = ADDR_W'(2 * BLOCK_WORDS - 1);
  localparam logic [WW-1:0] LastWord = WW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] dataQ;
  logic              isWr;
  logic              isD;
  logic [CW-1:0]     issueCnt;
  logic [WW-1:0]     retCnt;
  logic              settle;
  logic              fillToD;
`ifdef ARB_ROUND_ROBIN_EN
  logic              lastFillD;
`endif

  logic              grantWr;
  logic              grantD;
  logic              grantI;
  logic              issuing;
  logic [ADDR_W-1:0] baseAddr;

  assign baseAddr = addrQ & ~LowMask;
  assign issuing  = (state == FILL) && (issueCnt < CW'(BLOCK_WORDS));

  always_comb begin
    grantWr = 1'b0;
    grantD  = 1'b0;
    grantI  = 1'b0;
    if (state == IDLE && !settle) begin
      if (d_wr) begin
        grantWr = 1'b1;
      end else if (d_miss && i_miss) begin
`ifdef ARB_ROUND_ROBIN_EN
        grantD = !lastFillD;
        grantI = lastFillD;
`else
        grantD = 1'b1;
`endif
      end else if (d_miss) begin
        grantD = 1'b1;
      end else if (i_miss) begin
        grantI = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (grantWr) stateNext = WRITE;
        else if (grantD || grantI) stateNext = FILL;
      end
      WRITE: stateNext = DONE;
      FILL: begin
        if (mem_rvalid && retCnt == LastWord) stateNext = DONE;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_valid  = 1'b0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_done   = 1'b0;
    busy        = (state != IDLE);
    fill_to_d   = fillToD;
    if (state == WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = addrQ;
      mem_wdata = dataQ;
    end
    if (issuing) begin
      mem_en   = 1'b1;
      mem_addr = baseAddr + (ADDR_W'(issueCnt) << 1);
    end
    // returns outside FILL never reach the caches
    if (state == FILL && mem_rvalid) begin
      fill_valid = 1'b1;
      fill_data  = mem_rdata;
      fill_word  = retCnt;
    end
    if (state == DONE) begin
      d_wr_done   = isWr;
      d_fill_done = !isWr && isD;
      i_fill_done = !isWr && !isD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addrQ     <= '0;
      dataQ     <= '0;
      isWr      <= 1'b0;
      isD       <= 1'b0;
      issueCnt  <= '0;
      retCnt    <= '0;
      settle    <= 1'b0;
      fillToD   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastFillD <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      if (grantWr) begin
        addrQ <= d_wr_addr;
        dataQ <= d_wr_data;
        isWr  <= 1'b1;
        isD   <= 1'b1;
      end
      if (grantD || grantI) begin
        addrQ    <= grantD ? d_miss_addr : i_miss_addr;
        isWr     <= 1'b0;
        isD      <= grantD;
        issueCnt <= '0;
        retCnt   <= '0;
        fillToD  <= grantD;
`ifdef ARB_ROUND_ROBIN_EN
        lastFillD <= grantD;
`endif
      end
      if (issuing) issueCnt <= issueCnt + 1'b1;
      if (state == FILL && mem_rvalid) retCnt <= retCnt + 1'b1;
      // one idle cycle after DONE lets the requester drop its line
      if (state == DONE) settle <= 1'b1;
      else if (state == IDLE) settle <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle-latency memory model.
// Read data is address ^ 16'h5A5A so every returned word is checkable.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        fill_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        fill_to_d;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        d_wr_done;
  logic        busy;

  int errs = 0;
  int checks = 0;

  logic        forceRv = 1'b0;
  logic [3:0]  pv;
  logic [15:0] pa0, pa1, pa2, pa3;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr        (d_wr),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .fill_valid  (fill_valid),
    .fill_data   (fill_data),
    .fill_word   (fill_word),
    .fill_to_d   (fill_to_d),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_done   (d_wr_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv  <= {pv[2:0], mem_en & ~mem_wr};
      pa0 <= mem_addr;
      pa1 <= pa0;
      pa2 <= pa1;
      pa3 <= pa2;
    end
  end

  assign mem_rvalid = pv[3] | forceRv;
  assign mem_rdata  = forceRv ? 16'hDEAD : (pv[3] ? (pa3 ^ 16'h5A5A) : 16'h0);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fill(input logic [15:0] addr, input logic toD,
                            input int injectAt, input int abortAt);
    logic [15:0] base;
    logic [15:0] ea;
    logic [6:0]  exp;
    logic [6:0]  got;
    logic        eEn, eFv, eDone;
    base = addr & 16'hFFF0;
    for (int n = 1; n <= 13; n++) begin
      step();
      eEn   = (n <= 8);
      eFv   = (n >= 5) && (n <= 12);
      eDone = (n == 13);
      exp = {eEn, eFv, eDone & ~toD, eDone & toD, 1'b0, toD, 1'b1};
      got = {mem_en, fill_valid, i_fill_done, d_fill_done,
             d_wr_done, fill_to_d, busy};
      checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL fill_ctl base=%h n=%0d got=%b exp=%b",
                 base, n, got, exp);
      end
      checks++;
      if (mem_wr !== 1'b0) begin
        errs++;
        $display("FAIL fill_wr n=%0d got=%b exp=0", n, mem_wr);
      end
      if (eEn) begin
        ea = base + 16'(2 * (n - 1));
        checks++;
        if (mem_addr !== ea) begin
          errs++;
          $display("FAIL fill_addr n=%0d got=%h exp=%h", n, mem_addr, ea);
        end
      end
      if (eFv) begin
        ea = base + 16'(2 * (n - 5));
        checks++;
        if ({fill_word, fill_data} !== {3'(n - 5), ea ^ 16'h5A5A}) begin
          errs++;
          $display("FAIL fill_word n=%0d got=%0d/%h exp=%0d/%h", n,
                   fill_word, fill_data, n - 5, ea ^ 16'h5A5A);
        end
      end
      if (n == injectAt) begin
        d_wr        = 1'b1;
        d_wr_addr   = 16'h0100;
        d_wr_data   = 16'h1234;
        d_miss      = 1'b1;
        d_miss_addr = 16'h5000;
      end
      if (n == abortAt || n == 13) begin
        if (toD) d_miss = 1'b0;
        else i_miss = 1'b0;
        if (n == abortAt) begin
          rst = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic check_settle(input logic toD);
    step();
    checks++;
    if ({busy, mem_en, i_fill_done, d_fill_done, fill_to_d} !==
        {4'b0000, toD}) begin
      errs++;
      $display("FAIL settle got=%b exp=%b",
               {busy, mem_en, i_fill_done, d_fill_done, fill_to_d},
               {4'b0000, toD});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_miss = 1'b0;
    d_miss = 1'b0;
    d_wr = 1'b0;
    i_miss_addr = '0;
    d_miss_addr = '0;
    d_wr_addr = '0;
    d_wr_data = '0;
    step();
    step();
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_data,
         fill_word, fill_to_d, i_fill_done, d_fill_done, d_wr_done,
         busy} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got en=%b wr=%b addr=%h busy=%b exp all 0",
               mem_en, mem_wr, mem_addr, busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    d_wr = 1'b1;
    d_wr_addr = 16'h0040;
    d_wr_data = 16'hBEEF;
    checks++;
    if ({mem_en, busy} !== 2'b00) begin
      errs++;
      $display("FAIL wr_t0 got=%b exp=00", {mem_en, busy});
    end
    step();
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, d_wr_done} !==
        {2'b11, 16'h0040, 16'hBEEF, 1'b0}) begin
      errs++;
      $display("FAIL wr_mem got en=%b wr=%b addr=%h data=%h exp 1 1 0040 beef",
               mem_en, mem_wr, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if ({d_wr_done, i_fill_done, d_fill_done, mem_en} !== 4'b1000) begin
      errs++;
      $display("FAIL wr_done got=%b exp=1000",
               {d_wr_done, i_fill_done, d_fill_done, mem_en});
    end
    d_wr = 1'b0;
    step();
    checks++;
    if ({busy, d_wr_done, mem_en} !== 3'b000) begin
      errs++;
      $display("FAIL wr_after got=%b exp=000", {busy, d_wr_done, mem_en});
    end
    step();
  endtask

  task automatic test_ifill();
    i_miss = 1'b1;
    i_miss_addr = 16'h1236;
    check_fill(16'h1236, 1'b0, 0, 0);
    check_settle(1'b0);
    step();
  endtask

  task automatic test_rvalid_idle();
    forceRv = 1'b1;
    #1;
    checks++;
    if ({fill_valid, fill_data, busy} !== '0) begin
      errs++;
      $display("FAIL idle_rvalid got fv=%b data=%h busy=%b exp 0",
               fill_valid, fill_data, busy);
    end
    step();
    forceRv = 1'b0;
    i_miss = 1'b1;
    i_miss_addr = 16'h0A0C;
    check_fill(16'h0A0C, 1'b0, 0, 0);
    check_settle(1'b0);
    step();
  endtask

  task automatic test_tie();
    d_miss = 1'b1;
    d_miss_addr = 16'h2008;
    i_miss = 1'b1;
    i_miss_addr = 16'h3014;
    check_fill(16'h2008, 1'b1, 0, 0);
    check_settle(1'b1);
    d_miss = 1'b1;
    d_miss_addr = 16'h4002;
    step();
`ifdef ARB_ROUND_ROBIN_EN
    check_fill(16'h3014, 1'b0, 0, 0);
    check_settle(1'b0);
    step();
    check_fill(16'h4002, 1'b1, 0, 0);
    check_settle(1'b1);
`else
    check_fill(16'h4002, 1'b1, 0, 0);
    check_settle(1'b1);
    step();
    check_fill(16'h3014, 1'b0, 0, 0);
    check_settle(1'b0);
`endif
    step();
  endtask

  task automatic test_back_to_back();
    i_miss = 1'b1;
    i_miss_addr = 16'h7FFE;
    check_fill(16'h7FFE, 1'b0, 3, 0);
    check_settle(1'b0);
    step();
    checks++;
    if ({mem_en, busy} !== 2'b00) begin
      errs++;
      $display("FAIL b2b_sample got=%b exp=00", {mem_en, busy});
    end
    step();
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata} !==
        {2'b11, 16'h0100, 16'h1234}) begin
      errs++;
      $display("FAIL b2b_write got en=%b wr=%b addr=%h data=%h exp 1 1 0100 1234",
               mem_en, mem_wr, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if ({d_wr_done, d_fill_done} !== 2'b10) begin
      errs++;
      $display("FAIL b2b_wdone got=%b exp=10", {d_wr_done, d_fill_done});
    end
    d_wr = 1'b0;
    step();
    step();
    check_fill(16'h5000, 1'b1, 0, 0);
    check_settle(1'b1);
    step();
  endtask

  task automatic test_reset_mid();
    d_miss = 1'b1;
    d_miss_addr = 16'h6000;
    check_fill(16'h6000, 1'b1, 0, 7);
    step();
    rst = 1'b0;
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_data,
         fill_word, fill_to_d, i_fill_done, d_fill_done, d_wr_done,
         busy} !== '0) begin
      errs++;
      $display("FAIL rst_mid got en=%b fv=%b td=%b busy=%b exp all 0",
               mem_en, fill_valid, fill_to_d, busy);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({busy, fill_valid, i_fill_done, d_fill_done, d_wr_done} !== '0) begin
        errs++;
        $display("FAIL rst_quiet k=%0d got=%b exp=00000", k,
                 {busy, fill_valid, i_fill_done, d_fill_done, d_wr_done});
      end
    end
    d_miss = 1'b1;
    d_miss_addr = 16'h600A;
    check_fill(16'h600A, 1'b1, 0, 0);
    check_settle(1'b1);
    step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_ifill();
    test_rvalid_idle();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
